// File: rtl/perf_stat_pkg.sv
// Shared definitions for the performance-statistics UART transmitter.
// Holds the frame constants and the serializer state enumeration used
// by both the frame sequencer and the bit-level serializer.
package perf_stat_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 18;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready byte handshake.
// A byte is taken when valid && ready. Ready is high while idle and in the
// final cycle of a stop bit, so a waiting byte follows the previous stop
// bit with no idle gap.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   valid, data      byte offered by the sequencer
//   ready            serializer can take a byte this cycle
//   txd              serial line, idle high (registered)
//   busy             a byte is on the line
module uart_tx_byte
    import perf_stat_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd,
    output logic       busy
);

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (timer == BIT_LAST);
    assign ready   = (state == IDLE) || ((state == STOP_BIT) && bit_end);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (valid) begin
                        state <= START_BIT;
                        txd   <= 1'b0;
                        shreg <= data;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA_BITS;
                        txd     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        timer <= '0;
                        // Chain straight into the next byte's start bit when one is waiting.
                        if (valid) begin
                            state <= START_BIT;
                            txd   <= 1'b0;
                            shreg <= data;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/perf_stat_tx.sv
// Snapshots four performance counters on start and sends them as an
// 18-byte UART frame: A5, total, conditional, unconditional,
// conditional_success (each MSB byte first), then the XOR of the 16
// counter bytes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request a frame (ignored while a frame runs)
//   total, conditional,
//   unconditional,
//   conditional_success      32-bit counter inputs
//   txd                      serial line, idle high
//   busy                     frame in progress
//   done                     one-cycle pulse after the final stop bit
module perf_stat_tx
    import perf_stat_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] total,
    input  logic [31:0] conditional,
    input  logic [31:0] unconditional,
    input  logic [31:0] conditional_success,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FRAME_LEN = 5'(FRAME_BYTES);
    localparam logic [4:0] LAST_IDX  = 5'(FRAME_BYTES - 1);

    logic         active;
    logic [4:0]   byte_idx;
    logic [31:0]  snap_total, snap_cond, snap_uncond, snap_success;
    logic [127:0] snap_words;
    logic [3:0]   word_byte;
    logic         byte_valid, byte_ready;
    logic [7:0]   byte_data;

    function automatic logic [7:0] xor_fold(input logic [127:0] w);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ w[i*8 +: 8];
        end
        return acc;
    endfunction

    assign snap_words = {snap_total, snap_cond, snap_uncond, snap_success};

    // While idle the sync byte is offered directly from start, so the
    // serializer begins the start bit on the same edge that snapshots.
    assign byte_valid = active ? (byte_idx < FRAME_LEN) : start;

    always_comb begin
        word_byte = 4'(byte_idx - 5'd1);
        byte_data = SYNC_BYTE;
        if (active) begin
            if (byte_idx == LAST_IDX) begin
                byte_data = xor_fold(snap_words);
            end else if (byte_idx != 5'd0) begin
                byte_data = snap_words[{4'd15 - word_byte, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active       <= 1'b0;
            byte_idx     <= '0;
            done         <= 1'b0;
            snap_total   <= '0;
            snap_cond    <= '0;
            snap_uncond  <= '0;
            snap_success <= '0;
        end else begin
            done <= 1'b0;
            if (byte_valid && byte_ready) begin
                byte_idx <= byte_idx + 5'd1;
                if (!active) begin
                    active       <= 1'b1;
                    snap_total   <= total;
                    snap_cond    <= conditional;
                    snap_uncond  <= unconditional;
                    snap_success <= conditional_success;
                end
            end else if (active && byte_ready) begin
                // Last stop bit ends with nothing left to send.
                active   <= 1'b0;
                byte_idx <= '0;
                done     <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .valid(byte_valid),
        .data (byte_data),
        .ready(byte_ready),
        .txd  (txd),
        .busy (busy)
    );

endmodule

// File: doc/perf_stat_tx.md
PERF_STAT_TX -- requirements
Module: perf_stat_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clk cycles per UART bit (legal range >= 2).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to snapshot and transmit counters.
REQ-005 SHALL have port: total  input  32  cycle counter value.
REQ-006 SHALL have port: conditional  input  32  conditional-branch count.
REQ-007 SHALL have port: unconditional  input  32  jump count (j/jal/jr).
REQ-008 SHALL have port: conditional_success  input  32  correctly resolved branch count.
REQ-009 SHALL have port: txd  output  1  UART serial line, idle high.
REQ-010 SHALL have port: busy  output  1  frame in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 SHALL accept start only when the FSM is IDLE; start while busy is ignored, with no queuing.
REQ-013 SHALL, on the accepting edge, snapshot all four counters into internal 32-bit registers; later input changes do not affect the frame in flight.
REQ-014 SHALL transmit a frame of 18 bytes in this order: sync 0xA5, total, conditional, unconditional, conditional_success (each big-endian, MSB byte first), then a checksum byte.
REQ-015 SHALL compute the checksum as the XOR of the 16 counter bytes; the sync byte is excluded.
REQ-016 SHALL send each byte 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL drive txd low (start bit of sync) and busy high in the cycle after start is accepted.
REQ-018 SHALL send bytes back-to-back with no idle gap; the next start bit follows the previous stop bit immediately.
REQ-019 SHALL make the frame occupy exactly 18*10*CLKS_PER_BIT cycles of busy=1.
REQ-020 SHALL use FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT. Transitions:
- IDLE->START_BIT on accepted start.
- START_BIT->DATA_BITS when the bit timer expires.
- DATA_BITS->STOP_BIT after bit 7.
- STOP_BIT->START_BIT if the byte index is below 17.
- STOP_BIT->IDLE otherwise.
REQ-021 SHALL, in the first IDLE cycle after the final stop bit, assert done for one cycle with busy=0 and txd=1.
REQ-022 SHALL accept a start asserted in the same cycle as done, beginning a new frame next cycle.
REQ-023 SHALL size the bit timer ceil(log2(CLKS_PER_BIT)) bits, byte index 5 bits, and bit index 3 bits, with none wrapping during a frame.

Reset
REQ-024 SHALL, while rst=1, force: state IDLE, txd=1, busy=0, done=0, timers and indices 0, snapshot registers 0.
REQ-025 SHALL give rst priority over start in the same cycle.
REQ-026 SHALL, on reset asserted mid-frame, abort the frame; txd=1 from the next edge, no done pulse, and the partial frame is not resumed.

Structure
REQ-027 SHALL place SYNC_BYTE (0xA5), FRAME_BYTES (18), and the FSM state enumeration in shared package perf_stat_pkg.
REQ-028 SHALL factor the bit-level serializer into sub-module uart_tx_byte, with a valid/ready byte handshake and CLKS_PER_BIT passed through.
REQ-029 SHALL keep frame sequencing, snapshotting and checksum logic in perf_stat_tx.

Verification
REQ-030 SHALL cover: CLKS_PER_BIT=4, counters 0x00000010/0x3/0x2/0x1, start pulse -> bytes A5 00 00 00 10 00 00 00 03 00 00 00 02 00 00 00 01 10, busy high 720 cycles, then one done pulse.
REQ-031 SHALL cover: counters all 0xFFFFFFFF -> 16 bytes FF, checksum 0x00, each byte framed 0/11111111/1.
REQ-032 SHALL cover: start re-pulsed at cycles 5 and 300 of a frame -> ignored; exactly one frame of 18 bytes and one done.
REQ-033 SHALL cover: counter inputs changed every cycle after start -> transmitted values equal the values sampled on the accept edge.
REQ-034 SHALL cover: rst asserted during byte 7 -> txd=1 and busy=0 next cycle, no done; a subsequent start yields a complete correct frame.
REQ-035 SHALL cover: start held high continuously -> back-to-back frames, each start bit one cycle after the done cycle.
